// File: rtl/mbus_tx_arbiter.sv
// Round-robin arbiter sharing the single MBus TX port among NUM_CH requesters, holding the grant per message.
// Build option MBUS_TX_ARB_PRIO_EN: requesters with CH_PRIORITY=1 are searched ahead of normal ones.
// IDLE | no owner    WAIT_ACK | TX_REQ up      WAIT_ACKN | wait TX_ACK low    NEXT | wait next word
// WAIT_RESP | wait SUCC/FAIL    RESP | pulse CH_DONE, raise TX_RESP_ACK    RESP_CLR | wait SUCC/FAIL low
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mbus_tx_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [NUM_CH-1:0]             CH_REQ,
  input  logic [NUM_CH*`ADDR_WIDTH-1:0] CH_ADDR,
  input  logic [NUM_CH*`DATA_WIDTH-1:0] CH_DATA,
  input  logic [NUM_CH-1:0]             CH_PEND,
  input  logic [NUM_CH-1:0]             CH_PRIORITY,
  output logic [NUM_CH-1:0]             CH_GNT,
  output logic [NUM_CH-1:0]             CH_ACK,
  output logic [NUM_CH-1:0]             CH_DONE,
  output logic                          CH_FAIL,
  output logic                          BUSY,
  output logic [`ADDR_WIDTH-1:0]        TX_ADDR,
  output logic [`DATA_WIDTH-1:0]        TX_DATA,
  output logic                          TX_PEND,
  output logic                          TX_REQ,
  output logic                          PRIORITY,
  input  logic                          TX_ACK,
  input  logic                          TX_SUCC,
  input  logic                          TX_FAIL,
  output logic                          TX_RESP_ACK
);

  localparam int AW = `ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_ACK, S_WAIT_ACKN, S_NEXT, S_WAIT_RESP, S_RESP, S_RESP_CLR
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d, g_q, g_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d, ack_q, ack_d, done_q, done_d;
  logic              chfail_q, chfail_d, busy_q, fail_q, fail_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic              pend_q, pend_d, req_q, req_d, prio_q, prio_d, rack_q, rack_d;

  logic [NUM_CH-1:0] search;
  logic [PW-1:0]     win, sel;
  logic              win_vld;
  int                idx;

  // Nearest requester after the pointer wins, so iterate farthest-first and let later hits override.
  always_comb begin
    search = CH_REQ;
`ifdef MBUS_TX_ARB_PRIO_EN
    if (|(CH_REQ & CH_PRIORITY)) search = CH_REQ & CH_PRIORITY;
`endif
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = (int'(ptr_q) + i) % NUM_CH;
      if (search[idx]) begin
        win     = PW'(idx);
        win_vld = 1'b1;
      end
    end
  end

  assign sel = (state_q == S_IDLE) ? win : g_q;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    g_d      = g_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    done_d   = '0;
    chfail_d = 1'b0;
    fail_d   = fail_q;
    addr_d   = addr_q;
    data_d   = data_q;
    pend_d   = pend_q;
    prio_d   = prio_q;
    req_d    = req_q;
    rack_d   = rack_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          g_d     = win;
          gnt_d   = NUM_CH'(1) << win;
          addr_d  = CH_ADDR[int'(sel)*AW +: AW];
          data_d  = CH_DATA[int'(sel)*DW +: DW];
          pend_d  = CH_PEND[sel];
          prio_d  = CH_PRIORITY[sel];
          req_d   = 1'b1;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (TX_FAIL) begin
          req_d   = 1'b0;
          fail_d  = 1'b1;
          state_d = S_RESP;
        end else if (TX_ACK) begin
          req_d   = 1'b0;
          ack_d   = gnt_q;
          state_d = S_WAIT_ACKN;
        end
      end
      S_WAIT_ACKN: begin
        if (TX_FAIL) begin
          fail_d  = 1'b1;
          state_d = S_RESP;
        end else if (!TX_ACK) begin
          state_d = pend_q ? S_NEXT : S_WAIT_RESP;
        end
      end
      S_NEXT: begin
        if (TX_FAIL) begin
          fail_d  = 1'b1;
          state_d = S_RESP;
        end else if (CH_REQ[g_q]) begin
          addr_d  = CH_ADDR[int'(sel)*AW +: AW];
          data_d  = CH_DATA[int'(sel)*DW +: DW];
          pend_d  = CH_PEND[sel];
          prio_d  = CH_PRIORITY[sel];
          req_d   = 1'b1;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_RESP: begin
        if (TX_SUCC || TX_FAIL) begin
          fail_d  = TX_FAIL;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rack_d   = 1'b1;
        done_d   = gnt_q;
        chfail_d = fail_q;
        state_d  = S_RESP_CLR;
      end
      S_RESP_CLR: begin
        if (!TX_SUCC && !TX_FAIL) begin
          rack_d  = 1'b0;
          gnt_d   = '0;
          ptr_d   = g_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      ptr_q    <= PW'(NUM_CH - 1);
      g_q      <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      done_q   <= '0;
      chfail_q <= 1'b0;
      busy_q   <= 1'b0;
      fail_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      pend_q   <= 1'b0;
      req_q    <= 1'b0;
      prio_q   <= 1'b0;
      rack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      g_q      <= g_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      chfail_q <= chfail_d;
      busy_q   <= (state_d != S_IDLE);
      fail_q   <= fail_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      pend_q   <= pend_d;
      req_q    <= req_d;
      prio_q   <= prio_d;
      rack_q   <= rack_d;
    end
  end

  assign CH_GNT      = gnt_q;
  assign CH_ACK      = ack_q;
  assign CH_DONE     = done_q;
  assign CH_FAIL     = chfail_q;
  assign BUSY        = busy_q;
  assign TX_ADDR     = addr_q;
  assign TX_DATA     = data_q;
  assign TX_PEND     = pend_q;
  assign TX_REQ      = req_q;
  assign PRIORITY    = prio_q;
  assign TX_RESP_ACK = rack_q;

endmodule

// File: tb/tb_mbus_tx_arbiter.sv
// Bench for mbus_tx_arbiter: message-level reference model checked every cycle, plus literal spot checks.
module tb_mbus_tx_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  ch_req, ch_pend, ch_prio;
  logic [N*32-1:0] ch_addr, ch_data;
  logic          tx_ack, tx_succ, tx_fail;

  logic [N-1:0]  CH_GNT, CH_ACK, CH_DONE;
  logic          CH_FAIL, BUSY, TX_PEND, TX_REQ, PRIORITY, TX_RESP_ACK;
  logic [31:0]   TX_ADDR, TX_DATA;

  mbus_tx_arbiter #(.NUM_CH(N)) dut (
    .CLK(clk), .RESET(rst),
    .CH_REQ(ch_req), .CH_ADDR(ch_addr), .CH_DATA(ch_data),
    .CH_PEND(ch_pend), .CH_PRIORITY(ch_prio),
    .CH_GNT(CH_GNT), .CH_ACK(CH_ACK), .CH_DONE(CH_DONE), .CH_FAIL(CH_FAIL), .BUSY(BUSY),
    .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_PEND(TX_PEND), .TX_REQ(TX_REQ),
    .PRIORITY(PRIORITY), .TX_ACK(tx_ack), .TX_SUCC(tx_succ), .TX_FAIL(tx_fail),
    .TX_RESP_ACK(TX_RESP_ACK)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the message owner and what the bus side is waiting for.
  bit          m_live = 1'b0;
  int          m_own, w;
  int          m_order[$];
  bit          m_ackn, m_next, m_wresp, m_respnow, m_hold, m_fail;
  logic [N-1:0] elig;
  logic [N-1:0] e_gnt, e_ack, e_done;
  logic         e_chfail, e_busy, e_pend, e_req, e_prio, e_rack;
  logic [31:0]  e_addr, e_data;

  task automatic model_load(input int c);
    e_addr = ch_addr[c*32 +: 32];
    e_data = ch_data[c*32 +: 32];
    e_pend = ch_pend[c];
    e_prio = ch_prio[c];
    e_req  = 1'b1;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1'b1; m_own = -1; m_order = {0, 1, 2, 3};
      m_ackn = 0; m_next = 0; m_wresp = 0; m_respnow = 0; m_hold = 0; m_fail = 0;
      e_gnt = '0; e_ack = '0; e_done = '0; e_chfail = 0; e_pend = 0; e_req = 0;
      e_prio = 0; e_rack = 0; e_addr = '0; e_data = '0;
    end else begin
      e_ack = '0; e_done = '0; e_chfail = 1'b0;
      if (m_own < 0) begin
        elig = ch_req;
`ifdef MBUS_TX_ARB_PRIO_EN
        if ((ch_req & ch_prio) != '0) elig = ch_req & ch_prio;
`endif
        w = -1;
        foreach (m_order[k]) if (w < 0 && elig[m_order[k]]) w = m_order[k];
        if (w >= 0) begin
          m_own = w;
          e_gnt = 4'(1 << w);
          model_load(w);
        end
      end else if (m_hold) begin
        if (!tx_succ && !tx_fail) begin
          e_rack = 0; e_gnt = '0; m_hold = 0;
          while (m_order[0] != m_own) m_order.push_back(m_order.pop_front());
          m_order.push_back(m_order.pop_front());
          m_own = -1;
        end
      end else if (m_respnow) begin
        e_rack = 1; e_done = 4'(1 << m_own); e_chfail = m_fail;
        m_respnow = 0; m_hold = 1;
      end else if (tx_fail) begin
        e_req = 0; m_fail = 1; m_respnow = 1; m_ackn = 0; m_next = 0; m_wresp = 0;
      end else if (e_req) begin
        if (tx_ack) begin e_req = 0; e_ack = 4'(1 << m_own); m_ackn = 1; end
      end else if (m_ackn) begin
        if (!tx_ack) begin m_ackn = 0; if (e_pend) m_next = 1; else m_wresp = 1; end
      end else if (m_next) begin
        if (ch_req[m_own]) begin model_load(m_own); m_next = 0; end
      end else if (m_wresp) begin
        if (tx_succ) begin m_fail = 0; m_respnow = 1; m_wresp = 0; end
      end
    end
    e_busy = (m_own >= 0);
  end

  // Per-cycle compare plus logs of grants, acks and completions.
  int glog[$];
  int ack_cnt[N];
  int done_cnt = 0;
  logic last_fail = 1'b0;
  logic [N-1:0] prev_gnt = '0;

  always @(negedge clk) begin
    if (m_live) begin
      chk("CH_GNT", 64'(CH_GNT), 64'(e_gnt));
      chk("CH_ACK", 64'(CH_ACK), 64'(e_ack));
      chk("CH_DONE", 64'(CH_DONE), 64'(e_done));
      chk("CH_FAIL", 64'(CH_FAIL), 64'(e_chfail));
      chk("BUSY", 64'(BUSY), 64'(e_busy));
      chk("TX_ADDR", 64'(TX_ADDR), 64'(e_addr));
      chk("TX_DATA", 64'(TX_DATA), 64'(e_data));
      chk("TX_PEND", 64'(TX_PEND), 64'(e_pend));
      chk("TX_REQ", 64'(TX_REQ), 64'(e_req));
      chk("PRIORITY", 64'(PRIORITY), 64'(e_prio));
      chk("TX_RESP_ACK", 64'(TX_RESP_ACK), 64'(e_rack));
      if (CH_GNT != '0 && prev_gnt == '0)
        for (int k = 0; k < N; k++) if (CH_GNT[k]) glog.push_back(k);
      prev_gnt = CH_GNT;
      for (int k = 0; k < N; k++) if (CH_ACK[k]) ack_cnt[k]++;
      if (CH_DONE != '0) begin done_cnt++; last_fail = CH_FAIL; end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_hi(input int which, input string name);
    int n = 0;
    while (((which == 0) ? TX_REQ : TX_RESP_ACK) !== 1'b1 && n < 20) begin step(); n++; end
    if (((which == 0) ? TX_REQ : TX_RESP_ACK) !== 1'b1) begin
      vectors++; errors++;
      $display("FAIL %s: timeout waiting, got 0 expected 1", name);
    end
  endtask

  task automatic bus_ack(input int dly);
    wait_hi(0, "wait_tx_req");
    repeat (dly) step();
    tx_ack = 1'b1;
    step();
    tx_ack = 1'b0;
  endtask

  task automatic bus_resp(input int dly);
    repeat (dly) step();
    tx_succ = 1'b1;
    wait_hi(1, "wait_resp_ack");
    repeat (2) step();
    tx_succ = 1'b0;
    step();
    step();
  endtask

  task automatic set_word(input int c, input logic [31:0] a, input logic [31:0] d, input logic p);
    ch_addr[c*32 +: 32] = a;
    ch_data[c*32 +: 32] = d;
    ch_pend[c] = p;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int base;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ch_req = '0; ch_pend = '0; ch_prio = '0; ch_addr = '0; ch_data = '0;
    tx_ack = 0; tx_succ = 0; tx_fail = 0;
    for (int k = 0; k < N; k++) ack_cnt[k] = 0;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("reset_gnt", 64'(CH_GNT), 64'h0);
    chk("reset_busy", 64'(BUSY), 64'h0);
    chk("reset_txaddr", 64'(TX_ADDR), 64'h0);

    // single word on channel 0
    set_word(0, 32'h12, 32'hDEADBEEF, 1'b0);
    ch_req[0] = 1'b1;
    bus_ack(3);
    ch_req[0] = 1'b0;
    bus_resp(5);
    chk("single_addr", 64'(TX_ADDR), 64'h12);
    chk("single_data", 64'(TX_DATA), 64'hDEADBEEF);
    chk("single_acks", 64'(ack_cnt[0]), 64'd1);
    chk("single_done", 64'(done_cnt), 64'd1);
    chk("single_fail", 64'(last_fail), 64'h0);
    chk("single_busy", 64'(BUSY), 64'h0);

    // fairness from a fresh pointer
    pulse_reset();
    for (int k = 0; k < N; k++) set_word(k, 32'h100 + k, 32'h11111111 * k, 1'b0);
    base = glog.size();
    ch_req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      bus_ack(1);
      if (i == 4) ch_req = '0;
      bus_resp(1);
    end
    chk("fair_count", 64'(glog.size() - base), 64'd5);
    if (glog.size() >= base + 5) begin
      chk("fair_0", 64'(glog[base]), 64'd0);
      chk("fair_1", 64'(glog[base+1]), 64'd1);
      chk("fair_2", 64'(glog[base+2]), 64'd2);
      chk("fair_3", 64'(glog[base+3]), 64'd3);
      chk("fair_4", 64'(glog[base+4]), 64'd0);
    end

    // three-word message on channel 2 while channel 1 waits
    base = glog.size();
    ack_cnt[2] = 0;
    set_word(2, 32'h200, 32'hA0, 1'b1);
    ch_req[2] = 1'b1;
    bus_ack(2);
    ch_req[2] = 1'b0;
    set_word(1, 32'h111, 32'h5555, 1'b0);
    ch_req[1] = 1'b1;
    step();
    set_word(2, 32'h201, 32'hA1, 1'b1);
    ch_req[2] = 1'b1;
    bus_ack(1);
    ch_req[2] = 1'b0;
    step();
    set_word(2, 32'h202, 32'hA2, 1'b0);
    ch_req[2] = 1'b1;
    bus_ack(1);
    ch_req[2] = 1'b0;
    chk("multi_last_data", 64'(TX_DATA), 64'hA2);
    bus_resp(2);
    chk("multi_acks", 64'(ack_cnt[2]), 64'd3);
    bus_ack(1);
    ch_req[1] = 1'b0;
    bus_resp(1);
    chk("multi_grants", 64'(glog.size() - base), 64'd2);
    if (glog.size() >= base + 2) begin
      chk("multi_first", 64'(glog[base]), 64'd2);
      chk("multi_second", 64'(glog[base+1]), 64'd1);
    end

    // failure during WAIT_ACK of the second word
    set_word(3, 32'h300, 32'hB0, 1'b1);
    ch_req[3] = 1'b1;
    bus_ack(1);
    ch_req[3] = 1'b0;
    step();
    set_word(3, 32'h301, 32'hB1, 1'b0);
    ch_req[3] = 1'b1;
    wait_hi(0, "fail_wait_req");
    step();
    tx_fail = 1'b1;
    ch_req[3] = 1'b0;
    step();
    chk("fail_req_drop", 64'(TX_REQ), 64'h0);
    step();
    chk("fail_done", 64'(CH_DONE), 64'h8);
    chk("fail_flag", 64'(CH_FAIL), 64'h1);
    step();
    step();
    chk("fail_rack_hold", 64'(TX_RESP_ACK), 64'h1);
    tx_fail = 1'b0;
    step();
    chk("fail_rack_clr", 64'(TX_RESP_ACK), 64'h0);
    chk("fail_idle", 64'(BUSY), 64'h0);
    step();

    // reset while waiting for the next word
    set_word(0, 32'h400, 32'hC0, 1'b1);
    ch_req = 4'b0001;
    bus_ack(1);
    ch_req = '0;
    step();
    rst = 1'b1;
    step();
    chk("rstmid_gnt", 64'(CH_GNT), 64'h0);
    chk("rstmid_busy", 64'(BUSY), 64'h0);
    chk("rstmid_addr", 64'(TX_ADDR), 64'h0);
    rst = 1'b0;
    for (int k = 0; k < N; k++) set_word(k, 32'h500 + k, 32'hD0 + k, 1'b0);
    ch_req = 4'hF;
    step();
    chk("rstmid_regrant", 64'(CH_GNT), 64'h1);
    bus_ack(1);
    ch_req = '0;
    bus_resp(1);

    // priority requesters
    pulse_reset();
    ch_prio = 4'b0010;
    ch_req  = 4'b0011;
    step();
`ifdef MBUS_TX_ARB_PRIO_EN
    chk("prio_grant", 64'(CH_GNT), 64'h2);
`else
    chk("prio_grant", 64'(CH_GNT), 64'h1);
`endif
    bus_ack(1);
    ch_req = '0;
    bus_resp(1);
    ch_prio = '0;

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
